// File: rtl/reaction_game_ctrl_if.sv
// Signal bundle between the reaction game controller and its
// surroundings: frame timing and button pulses in, screen and score state out.
interface reaction_game_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_blue;
    logic       btn_red;
    logic [1:0] screen_sel;
    logic [1:0] hl_sel;
    logic [5:0] time_left;
    logic [7:0] score_blue;
    logic [7:0] score_red;
    logic [1:0] winner;

    modport master (
        output frame_tick, btn_start, btn_blue, btn_red,
        input  screen_sel, hl_sel, time_left, score_blue, score_red, winner
    );

    modport slave (
        input  frame_tick, btn_start, btn_blue, btn_red,
        output screen_sel, hl_sel, time_left, score_blue, score_red, winner
    );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Game flow and two-player press arbiter for the reaction game screen.
// Timing is counted in frame_tick pulses; every output is registered.
//
// state | meaning
// IDLE  | title screen, waits for start
// ARM   | block dark, cue delay counting down
// CUE   | block lit, waits for first press
// SHOW  | round result displayed for SHOW_FRAMES ticks
// OVER  | game-over screen with final winner
module reaction_game_ctrl #(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned GAME_SECONDS   = 30,
    parameter int unsigned MIN_DELAY      = 30,
    parameter bit          RAND_EN        = 1'b1,
    parameter int unsigned SHOW_FRAMES    = 60,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input logic                 clk,
    input logic                 rst,
    reaction_game_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CUE, S_SHOW, S_OVER} state_e;

    localparam logic [5:0] TIME_INIT = 6'(GAME_SECONDS);
    localparam logic [7:0] FPS_LAST  = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0] SHOW_LAST = 8'(SHOW_FRAMES - 1);
    localparam logic [8:0] DELAY_MIN = 9'(MIN_DELAY);

    state_e     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] show_cnt_q, show_cnt_d;
    logic [8:0] delay_cnt_q, delay_cnt_d;
    logic [5:0] time_q, time_d;
    logic [7:0] blue_q, blue_d;
    logic [7:0] red_q, red_d;
    logic       prio_q, prio_d;
    logic [1:0] round_q, round_d;
    logic [1:0] screen_q, screen_d;
    logic [1:0] hl_q, hl_d;
    logic [1:0] winner_q, winner_d;

    logic       play;
    logic       timeout;
    logic       load_delay;
    logic       blue_win;
    logic [8:0] delay_new;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        delay_new   = RAND_EN ? (DELAY_MIN + {3'b000, lfsr_q[5:0]}) : DELAY_MIN;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        show_cnt_d  = show_cnt_q;
        delay_cnt_d = delay_cnt_q;
        time_d      = time_q;
        blue_d      = blue_q;
        red_d       = red_q;
        prio_d      = prio_q;
        round_d     = round_q;
        screen_d    = 2'd1;
        hl_d        = 2'd0;
        winner_d    = 2'd0;
        timeout     = 1'b0;
        load_delay  = 1'b0;
        blue_win    = 1'b0;
        play        = (state_q == S_ARM) || (state_q == S_CUE) || (state_q == S_SHOW);

        if (play && bus.frame_tick) begin
            if (frame_cnt_q == FPS_LAST) begin
                frame_cnt_d = '0;
                time_d      = time_q - 6'd1;
                timeout     = (time_q == 6'd1);
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end

        // Running out of time overrides anything else happening this cycle.
        if (timeout) begin
            state_d = S_OVER;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.btn_start) begin
                        state_d     = S_ARM;
                        blue_d      = '0;
                        red_d       = '0;
                        time_d      = TIME_INIT;
                        frame_cnt_d = '0;
                        load_delay  = 1'b1;
                    end
                end
                S_ARM: begin
                    if (bus.btn_blue && bus.btn_red) begin
                        load_delay = 1'b1;
                    end else if (bus.btn_blue) begin
                        red_d      = sat_inc(red_q);
                        round_d    = 2'd3;
                        show_cnt_d = '0;
                        state_d    = S_SHOW;
                    end else if (bus.btn_red) begin
                        blue_d     = sat_inc(blue_q);
                        round_d    = 2'd2;
                        show_cnt_d = '0;
                        state_d    = S_SHOW;
                    end else if (bus.frame_tick) begin
                        delay_cnt_d = delay_cnt_q - 9'd1;
                        if (delay_cnt_q == 9'd1) begin
                            state_d = S_CUE;
                        end
                    end
                end
                S_CUE: begin
                    if (bus.btn_blue || bus.btn_red) begin
                        blue_win = bus.btn_blue && (!bus.btn_red || !prio_q);
                        if (bus.btn_blue && bus.btn_red) begin
                            prio_d = !prio_q;
                        end
                        if (blue_win) begin
                            blue_d  = sat_inc(blue_q);
                            round_d = 2'd2;
                        end else begin
                            red_d   = sat_inc(red_q);
                            round_d = 2'd3;
                        end
                        show_cnt_d = '0;
                        state_d    = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (bus.frame_tick) begin
                        if (show_cnt_q == SHOW_LAST) begin
                            state_d    = S_ARM;
                            load_delay = 1'b1;
                        end else begin
                            show_cnt_d = show_cnt_q + 8'd1;
                        end
                    end
                end
                S_OVER: begin
                    if (bus.btn_start) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (load_delay) begin
            delay_cnt_d = delay_new;
        end

        // Outputs are decoded from the next state so they land with the transition.
        case (state_d)
            S_IDLE: screen_d = 2'd0;
            S_CUE:  hl_d     = 2'd1;
            S_SHOW: hl_d     = round_d;
            S_OVER: begin
                screen_d = 2'd2;
                if (blue_d > red_d) begin
                    winner_d = 2'd1;
                end else if (blue_d < red_d) begin
                    winner_d = 2'd2;
                end else begin
                    winner_d = 2'd3;
                end
            end
            default: screen_d = 2'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            frame_cnt_q <= '0;
            show_cnt_q  <= '0;
            delay_cnt_q <= '0;
            time_q      <= TIME_INIT;
            blue_q      <= '0;
            red_q       <= '0;
            prio_q      <= 1'b0;
            round_q     <= 2'd0;
            screen_q    <= 2'd0;
            hl_q        <= 2'd0;
            winner_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            frame_cnt_q <= frame_cnt_d;
            show_cnt_q  <= show_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            time_q      <= time_d;
            blue_q      <= blue_d;
            red_q       <= red_d;
            prio_q      <= prio_d;
            round_q     <= round_d;
            screen_q    <= screen_d;
            hl_q        <= hl_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.screen_sel = screen_q;
    assign bus.hl_sel     = hl_q;
    assign bus.time_left  = time_q;
    assign bus.score_blue = blue_q;
    assign bus.score_red  = red_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: directed game scenarios plus a randomized
// press sequence checked against a game-rule model kept in the bench.
module tb_reaction_game_ctrl;
    localparam int FPS = 4, GS = 3, MIN_D = 2, SHOWF = 2;
    localparam int P_TITLE = 0, P_WAIT = 1, P_CUE = 2, P_SHOW = 3, P_OVER = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   tick_ctr = 0;
    bit   last_tick = 1'b0;

    // game-rule model: phase, scores, seconds left, frames into the second,
    // frames left before the cue, result frames shown, tie priority, round highlight
    int m_ph, m_blue, m_red, m_time, m_frm, m_wait, m_show, m_prio, m_round;

    reaction_game_ctrl_if bus();
    reaction_game_ctrl_if sbus();

    reaction_game_ctrl #(
        .FRAMES_PER_SEC(FPS), .GAME_SECONDS(GS), .MIN_DELAY(MIN_D),
        .RAND_EN(1'b0), .SHOW_FRAMES(SHOWF), .LFSR_SEED(8'hA5)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    // long game with a tick every clock so a score can be driven to saturation
    reaction_game_ctrl #(
        .FRAMES_PER_SEC(60), .GAME_SECONDS(63), .MIN_DELAY(1),
        .RAND_EN(1'b0), .SHOW_FRAMES(1), .LFSR_SEED(8'hA5)
    ) dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    always #5 clk = ~clk;

    function automatic int sat_add(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic model_update();
        bit tk, b, r, s, out_of_time;
        tk = bus.frame_tick; b = bus.btn_blue; r = bus.btn_red; s = bus.btn_start;
        if (!rst) begin
            m_ph = P_TITLE; m_blue = 0; m_red = 0; m_time = GS; m_frm = 0;
            m_wait = 0; m_show = 0; m_prio = 0; m_round = 0;
            return;
        end
        out_of_time = 1'b0;
        if ((m_ph == P_WAIT || m_ph == P_CUE || m_ph == P_SHOW) && tk) begin
            m_frm++;
            if (m_frm == FPS) begin
                m_frm = 0; m_time--; out_of_time = (m_time == 0);
            end
        end
        if (out_of_time) begin
            m_ph = P_OVER;
            return;
        end
        case (m_ph)
            P_TITLE: if (s) begin
                m_ph = P_WAIT; m_blue = 0; m_red = 0; m_time = GS; m_frm = 0; m_wait = MIN_D;
            end
            P_WAIT: begin
                if (b && r) m_wait = MIN_D;
                else if (b) begin m_red = sat_add(m_red); m_round = 3; m_ph = P_SHOW; m_show = 0; end
                else if (r) begin m_blue = sat_add(m_blue); m_round = 2; m_ph = P_SHOW; m_show = 0; end
                else if (tk) begin m_wait--; if (m_wait == 0) m_ph = P_CUE; end
            end
            P_CUE: if (b || r) begin
                if (b && r) begin
                    if (m_prio == 0) begin m_blue = sat_add(m_blue); m_round = 2; end
                    else begin m_red = sat_add(m_red); m_round = 3; end
                    m_prio = 1 - m_prio;
                end else if (b) begin m_blue = sat_add(m_blue); m_round = 2; end
                else begin m_red = sat_add(m_red); m_round = 3; end
                m_ph = P_SHOW; m_show = 0;
            end
            P_SHOW: if (tk) begin
                m_show++;
                if (m_show == SHOWF) begin m_ph = P_WAIT; m_wait = MIN_D; end
            end
            default: if (s) m_ph = P_TITLE;
        endcase
    endtask

    task automatic step(input bit b, input bit r, input bit s);
        last_tick = (tick_ctr == 9);
        tick_ctr = last_tick ? 0 : tick_ctr + 1;
        bus.frame_tick = last_tick; bus.btn_blue = b; bus.btn_red = r; bus.btn_start = s;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wait_hl(input logic [1:0] want, input int max_cyc, output int nticks, output bit ok);
        nticks = 0; ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.hl_sel === want) begin ok = 1'b1; return; end
            step(0, 0, 0);
            if (last_tick) nticks++;
        end
        ok = (bus.hl_sel === want);
    endtask

    task automatic new_game();
        rst = 1'b0; step(0, 0, 0); step(0, 0, 0);
        rst = 1'b1; tick_ctr = 0;
        step(0, 0, 1);
    endtask

    task automatic test_reset();
        rst = 1'b0; step(0, 0, 0); step(1, 1, 1);
        checks++;
        if (bus.screen_sel !== 2'd0 || bus.hl_sel !== 2'd0 || bus.winner !== 2'd0) begin
            failures++;
            $display("FAIL reset_sel got scr=%0d hl=%0d win=%0d want 0 0 0", bus.screen_sel, bus.hl_sel, bus.winner);
        end
        checks++;
        if (bus.time_left !== 6'(GS) || bus.score_blue !== 8'd0 || bus.score_red !== 8'd0) begin
            failures++;
            $display("FAIL reset_vals got t=%0d b=%0d r=%0d want %0d 0 0", bus.time_left, bus.score_blue, bus.score_red, GS);
        end
        rst = 1'b1; step(1, 1, 0);
        checks++;
        if (bus.screen_sel !== 2'd0 || bus.score_blue !== 8'd0 || bus.score_red !== 8'd0) begin
            failures++;
            $display("FAIL idle_buttons got scr=%0d b=%0d r=%0d want 0 0 0", bus.screen_sel, bus.score_blue, bus.score_red);
        end
    endtask

    task automatic test_single_round();
        int n; bit ok;
        new_game();
        checks++;
        if (bus.screen_sel !== 2'd1 || bus.hl_sel !== 2'd0 || bus.time_left !== 6'd3) begin
            failures++;
            $display("FAIL start got scr=%0d hl=%0d t=%0d want 1 0 3", bus.screen_sel, bus.hl_sel, bus.time_left);
        end
        wait_hl(2'd1, 60, n, ok);
        checks++;
        if (!ok || n != 2) begin failures++; $display("FAIL cue_delay got ok=%0d ticks=%0d want 1 2", ok, n); end
        step(0, 1, 0);
        checks++;
        if (bus.hl_sel !== 2'd3 || bus.score_red !== 8'd1 || bus.score_blue !== 8'd0) begin
            failures++;
            $display("FAIL red_win got hl=%0d r=%0d b=%0d want 3 1 0", bus.hl_sel, bus.score_red, bus.score_blue);
        end
        wait_hl(2'd0, 60, n, ok);
        checks++;
        if (!ok || n != 2 || bus.screen_sel !== 2'd1) begin
            failures++;
            $display("FAIL show_len got ok=%0d ticks=%0d scr=%0d want 1 2 1", ok, n, bus.screen_sel);
        end
    endtask

    task automatic test_tie_priority();
        int n; bit ok;
        logic [1:0] want_hl [3] = '{2'd2, 2'd3, 2'd2};
        int want_b [3] = '{1, 1, 2};
        int want_r [3] = '{0, 1, 1};
        new_game();
        for (int k = 0; k < 3; k++) begin
            wait_hl(2'd1, 60, n, ok);
            step(1, 1, 0);
            checks++;
            if (!ok || bus.hl_sel !== want_hl[k] || bus.score_blue !== 8'(want_b[k]) || bus.score_red !== 8'(want_r[k])) begin
                failures++;
                $display("FAIL tie_round%0d got ok=%0d hl=%0d b=%0d r=%0d want hl=%0d b=%0d r=%0d",
                         k, ok, bus.hl_sel, bus.score_blue, bus.score_red, want_hl[k], want_b[k], want_r[k]);
            end
            wait_hl(2'd0, 60, n, ok);
        end
        checks++;
        if (bus.screen_sel !== 2'd2 || bus.winner !== 2'd1) begin
            failures++;
            $display("FAIL tie_gameover got scr=%0d win=%0d want 2 1", bus.screen_sel, bus.winner);
        end
    endtask

    task automatic test_false_start();
        int n; bit ok; bit got_tick;
        new_game();
        step(1, 0, 0);
        checks++;
        if (bus.score_red !== 8'd1 || bus.score_blue !== 8'd0 || bus.hl_sel !== 2'd3) begin
            failures++;
            $display("FAIL false_blue got r=%0d b=%0d hl=%0d want 1 0 3", bus.score_red, bus.score_blue, bus.hl_sel);
        end
        wait_hl(2'd0, 60, n, ok);
        got_tick = 1'b0;
        for (int i = 0; i < 20 && !got_tick; i++) begin step(0, 0, 0); got_tick = last_tick; end
        step(1, 1, 0);
        checks++;
        if (!got_tick || bus.score_red !== 8'd1 || bus.score_blue !== 8'd0 || bus.hl_sel !== 2'd0) begin
            failures++;
            $display("FAIL false_both got tick=%0d r=%0d b=%0d hl=%0d want 1 1 0 0", got_tick, bus.score_red, bus.score_blue, bus.hl_sel);
        end
        wait_hl(2'd1, 60, n, ok);
        checks++;
        if (!ok || n != 2) begin failures++; $display("FAIL delay_restart got ok=%0d ticks=%0d want 1 2", ok, n); end
    endtask

    task automatic test_timeout();
        int tk; bit done; bit press;
        new_game();
        tk = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            press = (tick_ctr == 9) && (tk == 11);
            step(press, 0, 0);
            if (last_tick) begin
                tk++;
                if (tk == 3 || tk == 4 || tk == 8 || tk == 11) begin
                    checks++;
                    if (bus.time_left !== 6'(GS - tk / FPS)) begin
                        failures++;
                        $display("FAIL time_step tick=%0d got %0d want %0d", tk, bus.time_left, GS - tk / FPS);
                    end
                end
                if (tk == 12) done = 1'b1;
            end
        end
        checks++;
        if (!done || bus.screen_sel !== 2'd2 || bus.winner !== 2'd3 || bus.time_left !== 6'd0) begin
            failures++;
            $display("FAIL timeout got done=%0d scr=%0d win=%0d t=%0d want 1 2 3 0", done, bus.screen_sel, bus.winner, bus.time_left);
        end
        checks++;
        if (bus.score_blue !== 8'd0 || bus.score_red !== 8'd0) begin
            failures++;
            $display("FAIL timeout_press got b=%0d r=%0d want 0 0", bus.score_blue, bus.score_red);
        end
        step(1, 1, 0);
        checks++;
        if (bus.screen_sel !== 2'd2 || bus.score_blue !== 8'd0 || bus.winner !== 2'd3) begin
            failures++;
            $display("FAIL over_buttons got scr=%0d b=%0d win=%0d want 2 0 3", bus.screen_sel, bus.score_blue, bus.winner);
        end
        step(0, 0, 1);
        checks++;
        if (bus.screen_sel !== 2'd0) begin failures++; $display("FAIL over_restart got scr=%0d want 0", bus.screen_sel); end
    endtask

    task automatic test_reset_mid_game();
        int n; bit ok;
        new_game();
        for (int k = 0; k < 2; k++) begin
            wait_hl(2'd1, 60, n, ok); step(1, 0, 0); wait_hl(2'd0, 60, n, ok);
        end
        wait_hl(2'd1, 60, n, ok);
        checks++;
        if (!ok || bus.score_blue !== 8'd2) begin failures++; $display("FAIL pre_reset got ok=%0d b=%0d want 1 2", ok, bus.score_blue); end
        rst = 1'b0; step(0, 0, 0);
        checks++;
        if (bus.screen_sel !== 2'd0 || bus.hl_sel !== 2'd0 || bus.time_left !== 6'(GS) ||
            bus.score_blue !== 8'd0 || bus.score_red !== 8'd0 || bus.winner !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset got scr=%0d hl=%0d t=%0d b=%0d r=%0d win=%0d want 0 0 %0d 0 0 0",
                     bus.screen_sel, bus.hl_sel, bus.time_left, bus.score_blue, bus.score_red, bus.winner, GS);
        end
        rst = 1'b1; step(1, 0, 0); step(0, 0, 0);
        checks++;
        if (bus.score_blue !== 8'd0 || bus.screen_sel !== 2'd0 || bus.hl_sel !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_press got b=%0d scr=%0d hl=%0d want 0 0 0", bus.score_blue, bus.screen_sel, bus.hl_sel);
        end
    endtask

    task automatic test_saturation();
        bit over;
        rst = 1'b0; step(0, 0, 0); rst = 1'b1;
        sbus.frame_tick = 1'b1; sbus.btn_start = 1'b1;
        step(0, 0, 0);
        sbus.btn_start = 1'b0;
        over = 1'b0;
        for (int i = 0; i < 6000 && !over; i++) begin
            sbus.btn_blue = (sbus.hl_sel == 2'd1);
            step(0, 0, 0);
            over = (sbus.screen_sel == 2'd2);
        end
        sbus.frame_tick = 1'b0; sbus.btn_blue = 1'b0;
        checks++;
        if (!over || sbus.score_blue !== 8'd255 || sbus.score_red !== 8'd0 || sbus.winner !== 2'd1) begin
            failures++;
            $display("FAIL saturate got over=%0d b=%0d r=%0d win=%0d want 1 255 0 1", over, sbus.score_blue, sbus.score_red, sbus.winner);
        end
    endtask

    task automatic test_random_play();
        bit b, r, s;
        int e_scr, e_hl, e_win;
        new_game();
        for (int i = 0; i < 900; i++) begin
            b = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 40) == 0);
            step(b, r, s);
            e_scr = (m_ph == P_TITLE) ? 0 : (m_ph == P_OVER) ? 2 : 1;
            e_hl  = (m_ph == P_CUE) ? 1 : (m_ph == P_SHOW) ? m_round : 0;
            e_win = (m_ph != P_OVER) ? 0 : (m_blue > m_red) ? 1 : (m_blue < m_red) ? 2 : 3;
            checks++;
            if (bus.screen_sel !== 2'(e_scr) || bus.hl_sel !== 2'(e_hl) || bus.time_left !== 6'(m_time) ||
                bus.score_blue !== 8'(m_blue) || bus.score_red !== 8'(m_red) || bus.winner !== 2'(e_win)) begin
                failures++;
                $display("FAIL random_play cyc=%0d got scr=%0d hl=%0d t=%0d b=%0d r=%0d win=%0d want %0d %0d %0d %0d %0d %0d",
                         i, bus.screen_sel, bus.hl_sel, bus.time_left, bus.score_blue, bus.score_red, bus.winner,
                         e_scr, e_hl, m_time, m_blue, m_red, e_win);
            end
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.btn_start = 1'b0; bus.btn_blue = 1'b0; bus.btn_red = 1'b0;
        sbus.frame_tick = 1'b0; sbus.btn_start = 1'b0; sbus.btn_blue = 1'b0; sbus.btn_red = 1'b0;
        test_reset();
        test_single_round();
        test_tie_priority();
        test_false_start();
        test_timeout();
        test_reset_mid_game();
        test_saturation();
        test_random_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "simulation time limit reached");
    end
endmodule
